// File: rtl/demux4_word_collector.sv
// Collects the serial bits routed by a 1-to-4 demux into per-channel WIDTH-bit words.
// Each completed word is held for a consumer read. A newer word overwrites an unread one and sets a sticky overrun flag.
module demux4_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       y,
  input  logic [1:0]       s,
  input  logic             en,
  input  logic [3:0]       ch_clr,
  input  logic             rd_en,
  input  logic [1:0]       rd_ch,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [3:0]       word_valid,
  output logic [3:0]       overrun,
  output logic [3:0]       bit_cnt_nz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] sh        [4];
  logic [CW-1:0]    cnt       [4];
  logic [WIDTH-1:0] hold      [4];
  logic [WIDTH-1:0] word_next [4];

  logic       bit_in;
  logic       rd_ok;
  logic [3:0] cap;
  logic [3:0] done;
  logic [3:0] rd_hit;

  // y[s] is only consumed when en is high, so idle-cycle X on y never reaches state.
  always_comb begin
    bit_in     = y[s];
    rd_ok      = rd_en && word_valid[rd_ch];
    cap        = '0;
    done       = '0;
    rd_hit     = '0;
    bit_cnt_nz = '0;
    for (int c = 0; c < 4; c++) begin
      word_next[c]  = {sh[c], bit_in};
      cap[c]        = en && (s == 2'(c)) && !ch_clr[c];
      done[c]       = cap[c] && (cnt[c] == LAST);
      rd_hit[c]     = rd_ok && (rd_ch == 2'(c));
      bit_cnt_nz[c] = (cnt[c] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      word_valid <= '0;
      overrun    <= '0;
      for (int c = 0; c < 4; c++) begin
        sh[c]   <= '0;
        cnt[c]  <= '0;
        hold[c] <= '0;
      end
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= hold[rd_ch];
      end
      for (int c = 0; c < 4; c++) begin
        if (ch_clr[c]) begin
          cnt[c] <= '0;
        end else if (cap[c]) begin
          sh[c]  <= word_next[c][WIDTH-2:0];
          cnt[c] <= done[c] ? '0 : cnt[c] + CW'(1);
        end
        if (rd_hit[c]) begin
          word_valid[c] <= 1'b0;
          overrun[c]    <= 1'b0;
        end
        // Completion wins over a same-cycle read; overrun is set only if the old word is really lost.
        if (done[c]) begin
          hold[c]       <= word_next[c];
          word_valid[c] <= 1'b1;
          if (word_valid[c] && !rd_hit[c]) begin
            overrun[c] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux4_word_collector.sv
// Scoreboard bench for demux4_word_collector, covering directed scenarios followed by randomized traffic.
// The bench uses a behavioural per-channel bit-accumulation model.
module tb_demux4_word_collector;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       y;
  logic [1:0]       s;
  logic             en;
  logic [3:0]       ch_clr;
  logic             rd_en;
  logic [1:0]       rd_ch;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [3:0]       word_valid;
  logic [3:0]       overrun;
  logic [3:0]       bit_cnt_nz;

  demux4_word_collector #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .y(y), .s(s), .en(en), .ch_clr(ch_clr),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .word_valid(word_valid), .overrun(overrun), .bit_cnt_nz(bit_cnt_nz)
  );

  always #5 clk = ~clk;

  int               mcnt  [4];
  logic [31:0]      macc  [4];
  logic [WIDTH-1:0] mhold [4];
  logic             mvalid[4];
  logic             movr  [4];
  logic [WIDTH-1:0] expq  [$];
  logic [WIDTH-1:0] exp_last;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 4; c++) begin
      mcnt[c] = 0; macc[c] = '0; mhold[c] = '0; mvalid[c] = 1'b0; movr[c] = 1'b0;
    end
    expq.delete();
    exp_last = '0;
  endtask

  task automatic checkOutput();
    logic [3:0] wv, ov, nz;
    for (int c = 0; c < 4; c++) begin
      wv[c] = mvalid[c];
      ov[c] = movr[c];
      nz[c] = (mcnt[c] != 0);
    end
    check("word_valid", 32'(word_valid), 32'(wv));
    check("overrun", 32'(overrun), 32'(ov));
    check("bit_cnt_nz", 32'(bit_cnt_nz), 32'(nz));
  endtask

  // One cycle: check state left by the previous cycle, drive new inputs, advance the model.
  task automatic applyStimulus(input logic ien, input logic [1:0] is, input logic ib,
                               input logic [3:0] iclr, input logic ird, input logic [1:0] irch);
    logic rdok, rdhit, cap, complete, vb;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    checkOutput();
    en = ien; s = is; ch_clr = iclr; rd_en = ird; rd_ch = irch;
    if (ien) begin
      y = 4'($urandom);
      y[is] = ib;
    end else begin
      y = 4'bxxxx;
    end
    rdok = ird && mvalid[irch];
    if (rdok) expq.push_back(mhold[irch]);
    for (int c = 0; c < 4; c++) begin
      complete = 1'b0;
      w = '0;
      cap = ien && (is == 2'(c)) && !iclr[c];
      if (iclr[c]) begin
        mcnt[c] = 0; macc[c] = '0;
      end else if (cap) begin
        macc[c] = {macc[c][30:0], ib};
        mcnt[c]++;
        if (mcnt[c] == WIDTH) begin
          complete = 1'b1; w = macc[c][WIDTH-1:0]; mcnt[c] = 0; macc[c] = '0;
        end
      end
      rdhit = rdok && (irch == 2'(c));
      vb = mvalid[c];
      if (rdhit) begin mvalid[c] = 1'b0; movr[c] = 1'b0; end
      if (complete) begin
        if (vb && !rdhit) movr[c] = 1'b1;
        mhold[c] = w;
        mvalid[c] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b0, 4'b0, 1'b0, 2'd0);
  endtask

  task automatic readCh(input logic [1:0] ch);
    applyStimulus(1'b0, 2'd0, 1'b0, 4'b0, 1'b1, ch);
  endtask

  task automatic sendBits(input logic [1:0] ch, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, ch, bits[i], 4'b0, 1'b0, 2'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_bit_cnt_nz"}, 32'(bit_cnt_nz), 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
  task automatic pulseReset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    en = 1'b0; rd_en = 1'b0; ch_clr = '0; y = 4'bxxxx;
    #1 checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every rd_valid, otherwise rd_data must hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rd_valid) begin
          if (expq.size() == 0) begin
            check("unexpected_rd_valid", 32'(rd_valid), 32'h0);
          end else begin
            exp_last = expq.pop_front();
            check("rd_data", 32'(rd_data), 32'(exp_last));
          end
        end else begin
          check("rd_data_hold", 32'(rd_data), 32'(exp_last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] a5, c3, w77;
  initial begin
    en = 1'b0; s = '0; y = 4'bxxxx; ch_clr = '0; rd_en = 1'b0; rd_ch = '0;
    modelReset();
    #2 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    sendBits(2'd2, 32'hB2, 8);
    readCh(2'd2);
    idle();

    a5 = 8'hA5; c3 = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 2'd0, a5[i], 4'b0, 1'b0, 2'd0);
      if (i % 3 == 0) idle();
      applyStimulus(1'b1, 2'd3, c3[i], 4'b0, 1'b0, 2'd0);
    end
    idle();
    readCh(2'd0);
    readCh(2'd3);
    readCh(2'd1);

    sendBits(2'd1, 32'h11, 8);
    sendBits(2'd1, 32'h22, 8);
    readCh(2'd1);

    sendBits(2'd1, 32'h11, 8);
    w77 = 8'h77;
    for (int i = 7; i >= 1; i--) applyStimulus(1'b1, 2'd1, w77[i], 4'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd1, w77[0], 4'b0, 1'b1, 2'd1);
    readCh(2'd1);
    idle();

    sendBits(2'd0, 32'hD, 4);
    applyStimulus(1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 2'd0);
    sendBits(2'd0, 32'hF0, 8);
    readCh(2'd0);
    readCh(2'd0);
    idle();

    sendBits(2'd0, 32'h5A, 8);
    sendBits(2'd2, 32'h1F, 5);
    pulseReset();
    sendBits(2'd2, 32'h7, 3);
    sendBits(2'd2, 32'hC3, 8);
    readCh(2'd2);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom % 10) < 7, 2'($urandom), 1'($urandom),
                    (($urandom % 16) == 0) ? 4'($urandom) : 4'b0,
                    ($urandom % 10) < 3, 2'($urandom));
      if (n == 1500) pulseReset();
    end
    idle();
    idle();
    idle();
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
